// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State enum, FIFO entry layout, NOP encoding, default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int CNT_W = 3;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc, instr} entries; flush beats push.
// Ports: clk, rst_n, push_i, pop_i, flush_i, data_i, data_o, count_o.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     data_i,
  output fetch_entry_t     data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = (DEPTH > 2) ? 2 : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [AW-1:0]    rd_q, wr_q;
  logic [CNT_W-1:0] cnt_q;
  fetch_entry_t     mem_q [DEPTH];
  logic             do_push, do_pop;

  // Push at full is allowed only when the head leaves the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q < FULL) || do_pop);

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= inc(wr_q);
      if (do_pop)  rd_q <= inc(rd_q);
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, do_push}
                     - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues imem req/ack reads, buffers results.
// Ports: imem_* memory side, redirect_* restart, id_* decode side.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt (pops since reset).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt
`endif
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt;
  fetch_entry_t     head, wdata;
  logic             push, pop, has_space;
  logic [31:0]      rpc;
  logic [3:0]       used, cap;
  logic             unused_rpc;

  assign rpc        = {redirect_pc[31:2], 2'b00};
  assign unused_rpc = ^redirect_pc[1:0];

  assign pop  = id_valid && id_ready;
  assign push = (state_q == ST_WAIT) && imem_ack && !redirect_valid;

  // space > 0  <=>  count + push < depth + pop
  assign used      = 4'(cnt) + {3'b0, push};
  assign cap       = 4'(FIFO_DEPTH) + {3'b0, pop};
  assign has_space = used < cap;

  assign wdata.pc    = pc_q;
  assign wdata.instr = imem_rdata;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) begin
          pc_d    = rpc;
          addr_d  = rpc;
          req_d   = 1'b1;
          state_d = ST_WAIT;
        end else if (has_space) begin
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d = rpc;
          if (imem_ack) addr_d = rpc;
          else          state_d = ST_DROP;
        end else if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (has_space) begin
            addr_d = pc_q + 32'd4;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        // Abandoned request stays on the bus until its ack arrives.
        if (redirect_valid) pc_d = rpc;
        if (imem_ack) begin
          addr_d  = redirect_valid ? rpc : pc_q;
          state_d = ST_WAIT;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .data_i (wdata),
    .data_o (head),
    .count_o(cnt)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = (cnt != '0);
  assign id_instr  = id_valid ? head.instr : NOP_INSTR;
  assign id_pc     = id_valid ? head.pc : 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   perf_q <= '0;
    else if (pop) perf_q <= perf_q + 32'd1;
  end

  assign perf_fetch_cnt = perf_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable memory model.
// Memory returns ~addr as the instruction word.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  int wcnt;
  int ack_cnt;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (BASE),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  assign imem_ack   = imem_req && (wcnt >= lat);
  assign imem_rdata = ~imem_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt    <= 0;
      ack_cnt <= 0;
    end else begin
      if (!imem_req || imem_ack) wcnt <= 0;
      else                       wcnt <= wcnt + 1;
      if (imem_ack) ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    lat = l;
    id_ready = rdy;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  bit seen;
  bit got_it;

  initial begin
    @(negedge clk);

    // Reset values and streaming at one instruction per cycle
    do_reset(0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, BASE);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_instr", id_instr, 32'h0000_0013);
    check("rst_pc", id_pc, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf", perf_fetch_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, BASE);
    check("first_valid", 32'(id_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("stream_addr", imem_addr, BASE + 32'(4 * k));
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_pc", id_pc, BASE + 32'(4 * (k - 1)));
      check("stream_instr", id_instr, ~(BASE + 32'(4 * (k - 1))));
    end

    // Backpressure: two acks fill the buffer, then request drops
    do_reset(0, 1'b0);
    tick();
    tick();
    tick();
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(id_valid), 32'd1);
    check("stall_pc", id_pc, BASE);
    tick();
    tick();
    tick();
    check("stall_acks", 32'(ack_cnt), 32'd2);
    check("stall_req2", 32'(imem_req), 32'd0);
    check("stall_pc2", id_pc, BASE);
    id_ready = 1'b1;
    tick();
    check("drain_pc1", id_pc, BASE + 32'd4);
    check("resume_req", 32'(imem_req), 32'd1);
    check("resume_addr", imem_addr, BASE + 32'd8);
    tick();
    check("drain_pc2", id_pc, BASE + 32'd8);
    check("drain_instr2", id_instr, ~(BASE + 32'd8));

    // Redirect while a slow request is outstanding
    do_reset(3, 1'b1);
    tick();
    check("slow_addr", imem_addr, BASE);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    check("drop_addr", imem_addr, BASE);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_valid", 32'(id_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && imem_addr == BASE; i++) begin
      if (id_valid) seen = 1'b1;
      tick();
    end
    check("drop_no_data", 32'(seen), 32'd0);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_req", 32'(imem_req), 32'd1);
    got_it = 1'b0;
    for (int i = 0; i < 10 && !got_it; i++) begin
      if (id_valid) got_it = 1'b1;
      else tick();
    end
    check("redir_arrive", 32'(got_it), 32'd1);
    check("redir_pc", id_pc, 32'h0000_0100);
    check("redir_instr", id_instr, ~32'h0000_0100);

    // Redirect coinciding with ack, pop and a push that would fill
    do_reset(0, 1'b0);
    tick();
    tick();
    check("pre_valid", 32'(id_valid), 32'd1);
    check("pre_ack", 32'(imem_ack), 32'd1);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    check("flush_valid", 32'(id_valid), 32'd0);
    check("flush_instr", id_instr, 32'h0000_0013);
    check("flush_addr", imem_addr, 32'h0000_2000);
    check("flush_req", 32'(imem_req), 32'd1);
    tick();
    check("flush_pc", id_pc, 32'h0000_2000);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    check("wrap_valid0", 32'(id_valid), 32'd0);
    tick();
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    check("wrap_pc1", id_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr2", imem_addr, 32'h0000_0004);
    check("wrap_pc2", id_pc, 32'h0000_0000);

`ifdef FETCH_PERF_CNT_EN
    // Ten pops with a redirect in the middle
    do_reset(0, 1'b1);
    tick();
    tick();
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4000;
    tick();
    redirect_valid = 1'b0;
    tick();
    repeat (4) tick();
    check("perf_cnt", perf_fetch_cnt, 32'd10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
